// File: rtl/alu593_pkg.sv
// Shared types for the ALU593 parametrised datapath: opcodes, FSM states and opcode helpers.
package alu593_pkg;

  typedef enum logic [3:0] {
    OP_NO_OP    = 4'b0000,
    OP_ADD      = 4'b0001,
    OP_AND      = 4'b0010,
    OP_XOR      = 4'b0011,
    OP_MUL      = 4'b0100,
    OP_SP_FUNC1 = 4'b0101,
    OP_SP_FUNC2 = 4'b0110,
    OP_SP_FUNC3 = 4'b0111,
    OP_LOAD     = 4'b1000,
    OP_STORE    = 4'b1001,
    OP_RSVD1    = 4'b1010,
    OP_RSVD2    = 4'b1011,
    OP_RSVD3    = 4'b1100,
    OP_RSVD4    = 4'b1101,
    OP_RSVD5    = 4'b1110,
    OP_NO_OP1   = 4'b1111
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_ACC
  } state_t;

  function automatic logic is_reserved(input logic [3:0] code);
    return (code >= 4'b1010) && (code <= 4'b1110);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] code);
    return (code == OP_MUL) || (code == OP_SP_FUNC1);
  endfunction

endpackage

// File: rtl/alu593_mul_pipe.sv
// Registered unsigned WIDTH x WIDTH multiplier with a valid shift chain of MUL_LAT-1 stages.
module alu593_mul_pipe #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);

  // The FSM spends one edge consuming out_valid, so the pipe is one stage
  // shorter than MUL_LAT; MUL_LAT=1 cannot go below one registered stage.
  localparam int DEPTH = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  logic [DEPTH-1:0]   vld;
  logic [2*WIDTH-1:0] prod [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: product stages are qualified by vld, so the data array needs no reset.
  always_ff @(posedge clk) begin
    prod[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    for (int i = 1; i < DEPTH; i++) prod[i] <= prod[i-1];
  end

  assign out_valid = vld[DEPTH-1];
  assign product   = prod[DEPTH-1];

endmodule

// File: rtl/alu593_param.sv
// ALU593 parametrised top: start/done handshake, EXEC/MUL/ACC FSM, store/load register R.
// Optional build macro ALU593_SAT_ADD_EN makes add and sp_func1 saturate instead of carry/wrap.
module alu593_param
  import alu593_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [3:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int W2 = 2 * WIDTH;

  state_t             state, state_next;
  operation_t         op_q;
  logic [WIDTH-1:0]   a_q, b_q, r_q, r_next;
  logic [W2-1:0]      prod_q, result_next, exec_value, acc_value, mul_product;
  logic               done_next, err_next, prod_ld, accept, mul_valid;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic [W2:0]        acc_sum;

  // done still high means busy is still high, so a start on that cycle is dropped.
  assign accept = (state == ST_IDLE) && !done && start;
  assign busy   = (state != ST_IDLE) || done;

  alu593_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept && is_mul_op(op)),
    .a         (A),
    .b         (B),
    .out_valid (mul_valid),
    .product   (mul_product)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= operation_t'(op);
    end
    if (prod_ld) prod_q <= mul_product;
  end

  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = a_q - b_q;
    acc_sum  = {1'b0, prod_q} + {{(WIDTH+1){1'b0}}, r_q};
`ifdef ALU593_SAT_ADD_EN
    acc_value = acc_sum[W2] ? {W2{1'b1}} : acc_sum[W2-1:0];
`else
    acc_value = acc_sum[W2-1:0];
`endif
  end

  always_comb begin
    exec_value = result;
    case (op_q)
`ifdef ALU593_SAT_ADD_EN
      OP_ADD:      exec_value = add_sum[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                               : {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
`else
      OP_ADD:      exec_value = {{(WIDTH-1){1'b0}}, add_sum};
`endif
      OP_AND:      exec_value = {{WIDTH{1'b0}}, a_q & b_q};
      OP_XOR:      exec_value = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_SP_FUNC2: exec_value = {{WIDTH{sub_diff[WIDTH-1]}}, sub_diff};
      OP_SP_FUNC3: exec_value = {b_q, a_q};
      OP_LOAD:     exec_value = {{WIDTH{1'b0}}, r_q};
      default:     exec_value = result;
    endcase
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    result_next = result;
    done_next   = 1'b0;
    err_next    = 1'b0;
    r_next      = r_q;
    prod_ld     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = is_mul_op(op) ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: begin
        state_next  = ST_IDLE;
        done_next   = 1'b1;
        err_next    = is_reserved(op_q);
        result_next = exec_value;
        if (op_q == OP_STORE) r_next = a_q;
      end
      ST_MUL: begin
        if (mul_valid) begin
          if (op_q == OP_SP_FUNC1) begin
            state_next = ST_ACC;
            prod_ld    = 1'b1;
          end else begin
            state_next  = ST_IDLE;
            done_next   = 1'b1;
            result_next = mul_product;
          end
        end
      end
      ST_ACC: begin
        state_next  = ST_IDLE;
        done_next   = 1'b1;
        result_next = acc_value;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      r_q    <= '0;
    end else begin
      state  <= state_next;
      result <= result_next;
      done   <= done_next;
      err    <= err_next;
      r_q    <= r_next;
    end
  end

endmodule

// File: tb/tb_alu593_param.sv
// Directed self-checking bench for alu593_param at WIDTH=8, MUL_LAT=3.
module tb_alu593_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a, b;
  logic [3:0]  op;
  logic        start;
  logic        busy, done, err;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  alu593_param #(.WIDTH(8), .MUL_LAT(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (a),
    .B      (b),
    .op     (op),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Latency counts edges from the accept edge (1) to the edge that raises done.
  task automatic do_op(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                       output int lat, output logic e);
    wait_idle();
    a = va; b = vb; op = o; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    e = err;
  endtask

  int   lat, ndone, first;
  logic e;

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 16'h0000);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    do_op(4'b0001, 8'h01, 8'h02, lat, e);
    check("pre_add_result", result, 16'h0003);

    // Reset two cycles into a multiply aborts it.
    wait_idle();
    a = 8'h07; b = 8'h09; op = 4'b0100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_result_after", result, 16'h0000);
    check("abort_busy_after", busy, 1'b0);

    do_op(4'b0001, 8'h01, 8'h01, lat, e);
    check("add_lat", lat, 2);
    check("add_1_1", result, 16'h0002);

    do_op(4'b0001, 8'hFF, 8'h01, lat, e);
`ifdef ALU593_SAT_ADD_EN
    check("add_ff_01_sat", result, 16'h00FF);
`else
    check("add_ff_01", result, 16'h0100);
`endif

    do_op(4'b0010, 8'hF0, 8'h3C, lat, e);
    check("and", result, 16'h0030);
    do_op(4'b0011, 8'hF0, 8'h3C, lat, e);
    check("xor", result, 16'h00CC);

    // Multiply with an ignored xor start while busy and another on the done cycle.
    wait_idle();
    a = 8'hFF; b = 8'hFF; op = 4'b0100; start = 1'b1;
    ndone = 0; first = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (first == 0 || first == c) check("mul_busy", busy, 1'b1);
      @(negedge clk);
      if (c == 1 || c == 3) begin
        start = 1'b1; op = 4'b0011; a = 8'h0F; b = 8'hF0;
      end else begin
        start = 1'b0;
      end
    end
    check("mul_lat", first, 3);
    check("mul_one_done", ndone, 1);
    check("mul_ff_ff", result, 16'hFE01);

    do_op(4'b1001, 8'h10, 8'h00, lat, e);
    check("store_lat", lat, 2);
    check("store_result_kept", result, 16'hFE01);

    do_op(4'b0101, 8'h02, 8'h03, lat, e);
    check("sp1_lat", lat, 4);
    check("sp1_result", result, 16'h0016);

    do_op(4'b1000, 8'hAA, 8'h55, lat, e);
    check("load_result", result, 16'h0010);

    do_op(4'b0110, 8'h03, 8'h05, lat, e);
    check("sp2_result", result, 16'hFFFE);

    do_op(4'b0111, 8'h34, 8'h12, lat, e);
    check("sp3_result", result, 16'h1234);

    do_op(4'b1100, 8'h77, 8'h88, lat, e);
    check("rsvd_lat", lat, 2);
    check("rsvd_err", e, 1'b1);
    check("rsvd_result_kept", result, 16'h1234);

    do_op(4'b1111, 8'h77, 8'h88, lat, e);
    check("noop1_lat", lat, 2);
    check("noop1_err", e, 1'b0);
    check("noop1_result_kept", result, 16'h1234);

    do_op(4'b0000, 8'h01, 8'h01, lat, e);
    check("noop_result_kept", result, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
